// File: rtl/common_rewire_pkg.sv
// Shared sizing helpers and FSM encoding for the symbol/word rewire blocks.
package common_rewire_pkg;

  localparam int unsigned DFLT_NB_SYMBOL        = 4;
  localparam int unsigned DFLT_N_SYMBOLS_X_WORD = 3;
  localparam int unsigned DFLT_N_WORDS          = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic int unsigned nb_data(input int unsigned nb_symbol,
                                          input int unsigned n_symbols_x_word);
    return nb_symbol * n_symbols_x_word;
  endfunction

  // Index width never collapses to zero, even for a single-word vector.
  function automatic int unsigned nb_index(input int unsigned n_words);
    return (n_words > 32'd1) ? 32'($clog2(n_words)) : 32'd1;
  endfunction

  localparam int unsigned DFLT_NB_DATA  = nb_data(DFLT_NB_SYMBOL, DFLT_N_SYMBOLS_X_WORD);
  localparam int unsigned DFLT_NB_INDEX = nb_index(DFLT_N_WORDS);

endpackage

// File: rtl/common_a1b1a2b2_to_a1a2b1b2_rewire.sv
// Combinational inverse interleave: symbol slot jj*N_WORDS+ii becomes word ii, symbol jj.
module common_a1b1a2b2_to_a1a2b1b2_rewire
  import common_rewire_pkg::*;
#(
  parameter  int unsigned NB_SYMBOL        = DFLT_NB_SYMBOL,
  parameter  int unsigned N_SYMBOLS_X_WORD = DFLT_N_SYMBOLS_X_WORD,
  parameter  int unsigned N_WORDS          = DFLT_N_WORDS,
  localparam int unsigned NB_DATA          = nb_data(NB_SYMBOL, N_SYMBOLS_X_WORD),
  localparam int unsigned NB_VECTOR        = NB_DATA * N_WORDS
) (
  input  logic [NB_VECTOR-1:0] i_data_vector,
  output logic [NB_VECTOR-1:0] o_data_vector
);

  for (genvar ii = 0; ii < N_WORDS; ii++) begin : g_word
    for (genvar jj = 0; jj < N_SYMBOLS_X_WORD; jj++) begin : g_sym
      assign o_data_vector[NB_DATA*ii + NB_SYMBOL*jj +: NB_SYMBOL] =
        i_data_vector[NB_SYMBOL*(jj*N_WORDS + ii) +: NB_SYMBOL];
    end
  end

endmodule

// File: rtl/common_a1b1a2b2_to_a1a2b1b2_deserializer.sv
// Restores word-major order from a symbol-interleaved vector and streams one word per cycle.
// Optional sticky overflow flag: define COMMON_DESERIALIZER_OVERFLOW_EN.
module common_a1b1a2b2_to_a1a2b1b2_deserializer
  import common_rewire_pkg::*;
#(
  parameter  int unsigned NB_SYMBOL        = DFLT_NB_SYMBOL,
  parameter  int unsigned N_SYMBOLS_X_WORD = DFLT_N_SYMBOLS_X_WORD,
  parameter  int unsigned N_WORDS          = DFLT_N_WORDS,
  localparam int unsigned NB_DATA          = nb_data(NB_SYMBOL, N_SYMBOLS_X_WORD),
  localparam int unsigned NB_VECTOR        = NB_DATA * N_WORDS,
  localparam int unsigned NB_INDEX         = nb_index(N_WORDS)
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic [NB_VECTOR-1:0] i_data_vector,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [NB_DATA-1:0]   o_word,
  output logic [NB_INDEX-1:0]  o_word_index,
  output logic                 o_valid,
  output logic                 o_last,
  input  logic                 i_ready,
`ifdef COMMON_DESERIALIZER_OVERFLOW_EN
  output logic                 o_overflow,
  input  logic                 i_clear_overflow,
`endif
  output logic [NB_VECTOR-1:0] o_data_vector_rewired
);

  localparam logic [NB_INDEX-1:0] LAST_INDEX = NB_INDEX'(N_WORDS - 1);

  logic [NB_VECTOR-1:0] rewired_c;

  common_a1b1a2b2_to_a1a2b1b2_rewire #(
    .NB_SYMBOL        (NB_SYMBOL),
    .N_SYMBOLS_X_WORD (N_SYMBOLS_X_WORD),
    .N_WORDS          (N_WORDS)
  ) u_rewire (
    .i_data_vector (i_data_vector),
    .o_data_vector (rewired_c)
  );

  state_e               state_q, state_d;
  logic [NB_VECTOR-1:0] vec_q, vec_d;
  logic [NB_DATA-1:0]   word_q, word_d;
  logic [NB_INDEX-1:0]  index_q, index_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;

  logic                 ready_c;
  logic                 load_c;
  logic [NB_INDEX-1:0]  index_inc_c;
  logic [NB_DATA-1:0]   word_inc_c;

  // Ready early enough on the last word to reload without a bubble.
  assign ready_c     = (state_q == IDLE) | ((state_q == SEND) & last_q & i_ready);
  assign load_c      = i_valid & ready_c;
  assign index_inc_c = index_q + NB_INDEX'(1);

  always_comb begin
    word_inc_c = '0;
    for (int unsigned ii = 0; ii < N_WORDS; ii++) begin
      if (index_inc_c == NB_INDEX'(ii)) begin
        word_inc_c = vec_q[NB_DATA*ii +: NB_DATA];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    word_d  = word_q;
    index_d = index_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load_c) begin
      state_d = SEND;
      vec_d   = rewired_c;
      word_d  = rewired_c[NB_DATA-1:0];
      index_d = '0;
      valid_d = 1'b1;
      last_d  = (LAST_INDEX == '0);
    end else if ((state_q == SEND) && i_ready) begin
      if (last_q) begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        index_d = index_inc_c;
        word_d  = word_inc_c;
        last_d  = (index_inc_c == LAST_INDEX);
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      word_q  <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      word_q  <= word_d;
      index_q <= index_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

`ifdef COMMON_DESERIALIZER_OVERFLOW_EN
  logic overflow_q, overflow_d;

  // Sticky drop flag; an explicit clear takes priority over a new drop.
  always_comb begin
    overflow_d = overflow_q | (i_valid & ~ready_c);
    if (i_clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign o_overflow = overflow_q;
`endif

  assign o_ready               = ready_c;
  assign o_word                = word_q;
  assign o_word_index          = index_q;
  assign o_valid               = valid_q;
  assign o_last                = last_q;
  assign o_data_vector_rewired = vec_q;

endmodule

// File: tb/tb_common_a1b1a2b2_to_a1a2b1b2_deserializer.sv
// Scoreboard bench: default instance (4/3/2) with directed cases, plus an 8/3/4 instance for random round trips.
module tb_common_a1b1a2b2_to_a1a2b1b2_deserializer;

  typedef struct {
    logic [23:0]  word;
    logic [1:0]   idx;
    logic         last;
    logic [127:0] vec;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] a_data = '0, a_exp = '0;
  logic        a_valid = 1'b0, a_rdy = 1'b1;
  logic        a_ready, a_vld, a_last;
  logic [11:0] a_word;
  logic [0:0]  a_idx;
  logic [23:0] a_vec;

  logic [95:0] b_data = '0, b_exp = '0;
  logic        b_valid = 1'b0, b_rdy = 1'b1;
  logic        b_ready, b_vld, b_last;
  logic [23:0] b_word;
  logic [1:0]  b_idx;
  logic [95:0] b_vec;

`ifdef COMMON_DESERIALIZER_OVERFLOW_EN
  logic a_ovf, b_ovf;
  logic a_clr = 1'b0, b_clr = 1'b0;
`endif

  common_a1b1a2b2_to_a1a2b1b2_deserializer #(
    .NB_SYMBOL(4), .N_SYMBOLS_X_WORD(3), .N_WORDS(2)
  ) dut_a (
    .i_clock(clk), .i_reset_n(rst_n), .i_data_vector(a_data), .i_valid(a_valid),
    .o_ready(a_ready), .o_word(a_word), .o_word_index(a_idx), .o_valid(a_vld),
    .o_last(a_last), .i_ready(a_rdy),
`ifdef COMMON_DESERIALIZER_OVERFLOW_EN
    .o_overflow(a_ovf), .i_clear_overflow(a_clr),
`endif
    .o_data_vector_rewired(a_vec)
  );

  common_a1b1a2b2_to_a1a2b1b2_deserializer #(
    .NB_SYMBOL(8), .N_SYMBOLS_X_WORD(3), .N_WORDS(4)
  ) dut_b (
    .i_clock(clk), .i_reset_n(rst_n), .i_data_vector(b_data), .i_valid(b_valid),
    .o_ready(b_ready), .o_word(b_word), .o_word_index(b_idx), .o_valid(b_vld),
    .o_last(b_last), .i_ready(b_rdy),
`ifdef COMMON_DESERIALIZER_OVERFLOW_EN
    .o_overflow(b_ovf), .i_clear_overflow(b_clr),
`endif
    .o_data_vector_rewired(b_vec)
  );

  int n_vec = 0;
  int n_err = 0;
  sb_t qa[$];
  sb_t qb[$];
  bit a_fire, b_fire;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // TX-side interleave: word ii symbol jj goes to slot jj*nw+ii.
  function automatic logic [127:0] interleave(input logic [127:0] w, input int nbs,
                                              input int nsw, input int nw);
    logic [127:0] v;
    v = '0;
    for (int ii = 0; ii < nw; ii++)
      for (int jj = 0; jj < nsw; jj++)
        for (int b = 0; b < nbs; b++)
          v[(jj*nw + ii)*nbs + b] = w[(ii*nsw + jj)*nbs + b];
    return v;
  endfunction

  task automatic monitor();
    sb_t e;
    a_fire = a_valid && a_ready;
    b_fire = b_valid && b_ready;
    if (a_fire)
      for (int i = 0; i < 2; i++) begin
        e.word = 24'(a_exp[12*i +: 12]); e.idx = 2'(i); e.last = (i == 1); e.vec = 128'(a_exp);
        qa.push_back(e);
      end
    if (b_fire)
      for (int i = 0; i < 4; i++) begin
        e.word = b_exp[24*i +: 24]; e.idx = 2'(i); e.last = (i == 3); e.vec = 128'(b_exp);
        qb.push_back(e);
      end
    if (a_vld && a_rdy) begin
      if (qa.size() == 0) check("a_sb_depth", 128'(qa.size()), 128'(1));
      else begin
        e = qa.pop_front();
        check("a_word", 128'(a_word), 128'(e.word));
        check("a_idx",  128'(a_idx),  128'(e.idx));
        check("a_last", 128'(a_last), 128'(e.last));
        check("a_vec",  128'(a_vec),  e.vec);
      end
    end
    if (b_vld && b_rdy) begin
      if (qb.size() == 0) check("b_sb_depth", 128'(qb.size()), 128'(1));
      else begin
        e = qb.pop_front();
        check("b_word", 128'(b_word), 128'(e.word));
        check("b_idx",  128'(b_idx),  128'(e.idx));
        check("b_last", 128'(b_last), 128'(e.last));
        check("b_vec",  128'(b_vec),  e.vec);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [23:0] d, input logic [23:0] x);
    a_data = d; a_exp = x; a_valid = 1'b1;
  endtask

  int acc_a, acc_b, cyc;
  logic [23:0]  wa;
  logic [127:0] wb;

  initial begin
    #12;
    check("rst_valid", 128'(a_vld), 128'(0));
    check("rst_last",  128'(a_last), 128'(0));
    check("rst_word",  128'(a_word), 128'(0));
    check("rst_idx",   128'(a_idx), 128'(0));
    check("rst_vec",   128'(a_vec), 128'(0));
    check("rst_ready", 128'(a_ready), 128'(1));
    check("rst_b_ready", 128'(b_ready), 128'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single transfer, latency 1.
    load_a(24'h635241, 24'h654321); tick(); a_valid = 1'b0;
    check("st_valid0", 128'(a_vld), 128'(1));
    check("st_word0",  128'(a_word), 128'h321);
    check("st_idx0",   128'(a_idx), 128'(0));
    check("st_last0",  128'(a_last), 128'(0));
    check("st_ready0", 128'(a_ready), 128'(0));
    tick();
    check("st_word1",  128'(a_word), 128'h654);
    check("st_idx1",   128'(a_idx), 128'(1));
    check("st_last1",  128'(a_last), 128'(1));
    check("st_vec",    128'(a_vec), 128'h654321);
    check("st_ready1", 128'(a_ready), 128'(1));
    tick();
    check("st_idle",   128'(a_vld), 128'(0));

    // Backpressure holds the first word.
    load_a(24'h635241, 24'h654321); tick(); a_valid = 1'b0; a_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_word",  128'(a_word), 128'h321);
      check("bp_idx",   128'(a_idx), 128'(0));
      check("bp_ready", 128'(a_ready), 128'(0));
    end
    a_rdy = 1'b1; tick(); tick();
    check("bp_idle", 128'(a_vld), 128'(0));

    // Back-to-back with zero-bubble reload.
    load_a(24'h635241, 24'h654321); tick();
    load_a(24'hCFBEAD, 24'hCBAFED);
    check("b2b_w0", 128'(a_word), 128'h321);
    check("b2b_r0", 128'(a_ready), 128'(0));
    tick();
    check("b2b_w1", 128'(a_word), 128'h654);
    check("b2b_r1", 128'(a_ready), 128'(1));
    tick(); a_valid = 1'b0;
    check("b2b_fire", 128'(a_fire), 128'(1));
    check("b2b_w2", 128'(a_word), 128'hFED);
    check("b2b_v2", 128'(a_vld), 128'(1));
    check("b2b_i2", 128'(a_idx), 128'(0));
    tick();
    check("b2b_w3", 128'(a_word), 128'hCBA);
    check("b2b_l3", 128'(a_last), 128'(1));
    tick();
    check("b2b_idle", 128'(a_vld), 128'(0));

    // Vector offered while busy is dropped.
`ifdef COMMON_DESERIALIZER_OVERFLOW_EN
    a_clr = 1'b1;
`endif
    load_a(24'h635241, 24'h654321); tick(); a_valid = 1'b0; a_rdy = 1'b0;
`ifdef COMMON_DESERIALIZER_OVERFLOW_EN
    a_clr = 1'b0;
    check("ovf_clear0", 128'(a_ovf), 128'(0));
`endif
    load_a(24'hFFFFFF, 24'hFFFFFF); tick(); a_valid = 1'b0;
    check("ign_word", 128'(a_word), 128'h321);
    check("ign_idx",  128'(a_idx), 128'(0));
    check("ign_vec",  128'(a_vec), 128'h654321);
`ifdef COMMON_DESERIALIZER_OVERFLOW_EN
    check("ovf_set", 128'(a_ovf), 128'(1));
    a_clr = 1'b1; tick(); a_clr = 1'b0;
    check("ovf_clear1", 128'(a_ovf), 128'(0));
`endif
    a_rdy = 1'b1; tick(); tick();
    check("ign_idle", 128'(a_vld), 128'(0));

    // Asynchronous reset mid-transfer.
    load_a(24'h635241, 24'h654321); tick(); a_valid = 1'b0; a_rdy = 1'b0;
    check("mr_pending", 128'(a_word), 128'h321);
    rst_n = 1'b0; #1;
    check("mr_valid", 128'(a_vld), 128'(0));
    check("mr_vec",   128'(a_vec), 128'(0));
    check("mr_word",  128'(a_word), 128'(0));
    check("mr_ready", 128'(a_ready), 128'(1));
    qa.delete(); qb.delete();
    tick(); rst_n = 1'b1; a_rdy = 1'b1;
    check("mr_ready_rel", 128'(a_ready), 128'(1));
    load_a(24'hCFBEAD, 24'hCBAFED); tick(); a_valid = 1'b0;
    check("mr_new_w0", 128'(a_word), 128'hFED);
    tick(); tick();

    // Random round trip through the TX interleave on both instances.
    acc_a = 0; acc_b = 0;
    for (cyc = 0; cyc < 40000 && !(acc_a >= 1000 && acc_b >= 1000); cyc++) begin
      if (!a_valid && acc_a < 1000 && $urandom_range(3) != 0) begin
        wa = 24'($urandom());
        load_a(24'(interleave(128'(wa), 4, 3, 2)), wa);
      end
      if (!b_valid && acc_b < 1000 && $urandom_range(3) != 0) begin
        wb = 128'({$urandom(), $urandom(), $urandom()});
        b_exp = 96'(wb); b_data = 96'(interleave(wb, 8, 3, 4)); b_valid = 1'b1;
      end
      a_rdy = ($urandom_range(3) != 0);
      b_rdy = ($urandom_range(3) != 0);
      tick();
      if (a_fire) begin a_valid = 1'b0; acc_a++; end
      if (b_fire) begin b_valid = 1'b0; acc_b++; end
    end
    check("rand_acc_a", 128'(acc_a), 128'(1000));
    check("rand_acc_b", 128'(acc_b), 128'(1000));
    a_valid = 1'b0; b_valid = 1'b0; a_rdy = 1'b1; b_rdy = 1'b1;
    for (int i = 0; i < 100 && (qa.size() != 0 || qb.size() != 0); i++) tick();
    check("drain_a", 128'(qa.size()), 128'(0));
    check("drain_b", 128'(qb.size()), 128'(0));
    check("end_idle_a", 128'(a_vld), 128'(0));
    check("end_idle_b", 128'(b_vld), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
